act_quant: RTL and testbench

//  Post-MVM activation stage. Accepts a vector of signed accumulator results from the

---
 rtl/act_quant.sv | 150 +++++++++++++++
 tb/tb_act_quant.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_quant.sv
`default_nettype none
// ============================================================================
// Module   : act_quant
// Purpose  : Post-MVM activation stage: bias add, optional ReLU, requantizing
//            arithmetic right shift with saturation, one element per cycle.
//            Define ACT_ROUND_EN to round half up before the shift.
// Revision : 1.0 - initial release
// ============================================================================
module act_quant #(
    parameter int ROWS      = 6,
    parameter int ACC_WIDTH = 20,
    parameter int WIDTH     = 8,
    parameter int SHIFT_W   = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*ACC_WIDTH-1:0] acc_vec,
    input  logic [ROWS*ACC_WIDTH-1:0] bias_vec,
    input  logic [SHIFT_W-1:0]        shift,
    input  logic                      relu_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ROWS*WIDTH-1:0]     act_vec,
    output logic                      busy
);

    localparam int c_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_SUM_W = ACC_WIDTH + 2;
    localparam logic signed [c_SUM_W-1:0] c_QMAX = c_SUM_W'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [c_SUM_W-1:0] c_QMIN = c_SUM_W'(-(2 ** (WIDTH - 1)));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [c_IDX_W-1:0]        idx_q, idx_d;
    logic [ROWS*ACC_WIDTH-1:0] acc_q;
    logic [ROWS*ACC_WIDTH-1:0] bias_q;
    logic [SHIFT_W-1:0]        shift_q;
    logic                      relu_q;
    logic [ROWS*WIDTH-1:0]     act_q;
    logic                      w_accept;

    logic [ACC_WIDTH-1:0]      w_acc_sel;
    logic [ACC_WIDTH-1:0]      w_bias_sel;
    logic signed [c_SUM_W-1:0] w_sum;
    logic signed [c_SUM_W-1:0] w_relu;
    logic signed [c_SUM_W-1:0] w_pre;
    logic signed [c_SUM_W-1:0] w_shr;
    logic [31:0]               w_s;
    logic [WIDTH-1:0]          w_q;

    assign in_ready  = (state_q == S_IDLE) & ~reset;
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign act_vec   = act_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        w_accept = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    idx_d    = '0;
                    state_d  = S_PROC;
                end
            end
            S_PROC: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == c_IDX_W'(ROWS - 1)) begin
                    idx_d   = '0;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Element datapath: the sum is two bits wider than the operands so that
    // neither the bias add nor the rounding offset can overflow.
    always_comb begin
        w_acc_sel  = '0;
        w_bias_sel = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (idx_q == c_IDX_W'(i)) begin
                w_acc_sel  = acc_q[i*ACC_WIDTH +: ACC_WIDTH];
                w_bias_sel = bias_q[i*ACC_WIDTH +: ACC_WIDTH];
            end
        end
        w_sum  = {{2{w_acc_sel[ACC_WIDTH-1]}}, w_acc_sel}
               + {{2{w_bias_sel[ACC_WIDTH-1]}}, w_bias_sel};
        w_relu = (relu_q && w_sum[c_SUM_W-1]) ? '0 : w_sum;
        w_s    = (32'(shift_q) > 32'(ACC_WIDTH)) ? 32'(ACC_WIDTH) : 32'(shift_q);
`ifdef ACT_ROUND_EN
        w_pre  = w_relu + ((w_s != 32'd0) ? (c_SUM_W'(1) << (w_s - 32'd1)) : '0);
`else
        w_pre  = w_relu;
`endif
        w_shr  = w_pre >>> w_s;
        if (w_shr > c_QMAX) begin
            w_q = c_QMAX[WIDTH-1:0];
        end else if (w_shr < c_QMIN) begin
            w_q = c_QMIN[WIDTH-1:0];
        end else begin
            w_q = w_shr[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            bias_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (w_accept) begin
                acc_q   <= acc_vec;
                bias_q  <= bias_vec;
                shift_q <= shift;
                relu_q  <= relu_en;
            end
            if (state_q == S_PROC) begin
                for (int i = 0; i < ROWS; i++) begin
                    if (idx_q == c_IDX_W'(i)) begin
                        act_q[i*WIDTH +: WIDTH] <= w_q;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_act_quant.sv
`default_nettype none
// ============================================================================
// Module   : tb_act_quant
// Purpose  : Randomized and directed scoreboard bench for act_quant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_act_quant;

    localparam int ROWS = 6;
    localparam int AW   = 20;
    localparam int W    = 8;
    localparam int SW   = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [ROWS*AW-1:0] acc_vec;
    logic [ROWS*AW-1:0] bias_vec;
    logic [SW-1:0]      shift;
    logic               relu_en;
    logic               out_valid;
    logic               out_ready;
    logic [ROWS*W-1:0]  act_vec;
    logic               busy;

    act_quant #(.ROWS(ROWS), .ACC_WIDTH(AW), .WIDTH(W), .SHIFT_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_vec   (acc_vec),
        .bias_vec  (bias_vec),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .act_vec   (act_vec),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [ROWS*W-1:0] exp_q[$];
    int                acc_cyc_q[$];
    int                rdy_mode;   // 0 random, 1 hold low, 2 always high
    int                va[ROWS];
    int                vb[ROWS];

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact integer arithmetic with floor division by 2^s.
    function automatic int ref_elem(input int a, input int b, input int sh, input bit relu);
        longint sum, d, q;
        int     s;
        sum = longint'(a) + longint'(b);
        if (relu && sum < 0) sum = 0;
        s = (sh > AW) ? AW : sh;
        d = longint'(1) << s;
`ifdef ACT_ROUND_EN
        if (s > 0) sum = sum + d / 2;
`endif
        if (sum >= 0) q = sum / d;
        else          q = -((-sum + d - 1) / d);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 600)) - 300;
            1:       return int'($urandom_range(0, (1 << AW) - 1)) - (1 << (AW - 1));
            2:       return ($urandom_range(0, 1) != 0) ? (1 << (AW - 1)) - 1 : -(1 << (AW - 1));
            default: return int'($urandom_range(0, 4000)) - 2000;
        endcase
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < ROWS; i++) begin
            acc_vec[i*AW +: AW]  = AW'($urandom);
            bias_vec[i*AW +: AW] = AW'($urandom);
        end
        shift   = SW'($urandom);
        relu_en = 1'($urandom);
    endtask

    // Offers va/vb until accepted; returns on the falling edge after the accept edge.
    task automatic send(input int sh, input bit relu);
        logic [ROWS*W-1:0] e;
        int n;
        for (int i = 0; i < ROWS; i++) e[i*W +: W] = W'(ref_elem(va[i], vb[i], sh, relu));
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
            acc_vec[i*AW +: AW]  = AW'(va[i]);
            bias_vec[i*AW +: AW] = AW'(vb[i]);
        end
        shift   = SW'(sh);
        relu_en = relu;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        acc_cyc_q.push_back(cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard when it grants out_ready on a valid output.
    initial begin
        logic [ROWS*W-1:0] prev;
        logic [ROWS*W-1:0] e;
        bit seen;
        seen      = 1'b0;
        prev      = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen      = 1'b0;
                out_ready = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    prev = act_vec;
                    // cycle 1 is the cycle that follows the accept edge
                    if (acc_cyc_q.size() != 0) check("latency", cyc - acc_cyc_q[0] + 1, ROWS + 1);
                end else begin
                    check("act_stable", act_vec, prev);
                end
                check("in_ready_in_out", in_ready, 0);
                case (rdy_mode)
                    0:       out_ready = 1'($urandom_range(0, 1));
                    1:       out_ready = 1'b0;
                    default: out_ready = 1'b1;
                endcase
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        void'(acc_cyc_q.pop_front());
                        check("act_vec", act_vec, e);
                    end
                    seen = 1'b0;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
    end

    initial begin
        logic [ROWS*W-1:0] held;
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        rdy_mode = 0;
        scramble_inputs();
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_act_vec", act_vec, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Directed vectors
        va = '{100, -50, 300, 0, 7, -1};  vb = '{0, 0, 0, 0, 0, 0};
        send(0, 1'b0);
        va = '{-10, 5, -3, 0, 50, -50};   vb = '{20, -10, 3, -1, 0, 60};
        send(0, 1'b1);
        va = '{255, -255, 24, 23, 16, -16}; vb = '{0, 0, 0, 0, 0, 0};
        send(4, 1'b0);
        va = '{524287, -524288, 0, 0, 0, 0}; vb = '{524287, -524288, 0, 0, 0, 0};
        send(0, 1'b0);
        va = '{-1, 0, 0, 0, 0, 0};        vb = '{0, 0, 0, 0, 0, 0};
        send(31, 1'b0);
        drain();

        // Hold output while downstream stalls; input pulses must be ignored
        rdy_mode = 1;
        va = '{100, -50, 300, 0, 7, -1};  vb = '{0, 0, 0, 0, 0, 0};
        send(0, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_reach_out", out_valid, 1);
        held = act_vec;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_act_held", act_vec, held);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rdy_mode = 2;
        n = 0;
        while (out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_busy", busy, 0);
        check("release_queue", exp_q.size(), 0);

        // Reset in the middle of processing
        rdy_mode = 0;
        send(0, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_act_vec", act_vec, 0);
        check("abort_busy", busy, 0);
        void'(exp_q.pop_back());
        void'(acc_cyc_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        send(0, 1'b0);
        drain();

        // Random traffic with random downstream backpressure
        for (int t = 0; t < 40; t++) begin
            int sh;
            for (int i = 0; i < ROWS; i++) begin
                va[i] = rnd_val();
                vb[i] = rnd_val();
            end
            sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
            send(sh, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
